// File: rtl/axi4_burst_mem_pkg.sv
// Shared definitions for the AXI4 burst memory slave: burst/response codes,
// FSM state encodings and small helpers used by the top and address generator.
package axi4_burst_mem_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } w_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_t;

    // Number of byte lanes on a bus of the given width.
    function automatic int unsigned byte_lanes(input int unsigned data_width);
        return data_width / 8;
    endfunction

    // WRAP bursts are only defined for 2, 4, 8 or 16 beats.
    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational AXI beat address generator: given the current beat address and
// the burst attributes, produces the address of the following beat.
module axi_burst_addr_gen
    import axi4_burst_mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [2:0]            size,
    input  logic [7:0]            len,
    input  logic [1:0]            burst,
    output logic [ADDR_WIDTH-1:0] next_addr,
    output logic                  wrap_legal
);

    logic [ADDR_WIDTH-1:0] step;
    logic [ADDR_WIDTH-1:0] step_mask;
    logic [ADDR_WIDTH-1:0] aligned;
    logic [ADDR_WIDTH-1:0] wrap_mask;
    logic [2:0]            wrap_log;

    // Next address: FIXED holds, INCR steps from the aligned address (so an
    // unaligned start realigns after beat 0), legal WRAP stays in its block.
    always_comb begin
        wrap_legal = wrap_len_ok(len);
        step       = ADDR_WIDTH'(1) << size;
        step_mask  = step - ADDR_WIDTH'(1);
        aligned    = addr & ~step_mask;
        case (len)
            8'd1:    wrap_log = 3'd1;
            8'd3:    wrap_log = 3'd2;
            8'd7:    wrap_log = 3'd3;
            default: wrap_log = 3'd4;
        endcase
        wrap_mask  = (step << wrap_log) - ADDR_WIDTH'(1);
        next_addr  = aligned + step;
        if (burst == BURST_FIXED) begin
            next_addr = addr;
        end else if ((burst == BURST_WRAP) && wrap_legal) begin
            next_addr = (addr & ~wrap_mask) | ((aligned + step) & wrap_mask);
        end
    end

endmodule

// File: rtl/axi4_burst_mem.sv
// AXI4 slave backed by a simple dual-port on-chip memory. Independent write
// and read FSMs; FIXED/INCR/WRAP bursts, narrow transfers, byte strobes and
// SLVERR for out-of-range or malformed beats.
module axi4_burst_mem
    import axi4_burst_mem_pkg::*;
#(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 32,
    parameter int unsigned C_S_AXI_ID_WIDTH   = 4,
    parameter int unsigned C_MEM_DEPTH        = 1024
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_AWID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [7:0]                      S_AXI_AWLEN,
    input  logic [2:0]                      S_AXI_AWSIZE,
    input  logic [1:0]                      S_AXI_AWBURST,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WLAST,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_BID,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_ARID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [7:0]                      S_AXI_ARLEN,
    input  logic [2:0]                      S_AXI_ARSIZE,
    input  logic [1:0]                      S_AXI_ARBURST,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_RID,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RLAST,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY
);

    localparam int unsigned AW       = C_S_AXI_ADDR_WIDTH;
    localparam int unsigned DW       = C_S_AXI_DATA_WIDTH;
    localparam int unsigned IW       = C_S_AXI_ID_WIDTH;
    localparam int unsigned NB       = byte_lanes(DW);
    localparam int unsigned LB       = $clog2(NB);
    localparam int unsigned IDX_W    = $clog2(C_MEM_DEPTH);
    localparam logic [2:0]  BUS_SIZE = 3'(LB);

    logic [DW-1:0] mem [C_MEM_DEPTH];

    function automatic logic in_range(input logic [AW-1:0] a);
        return (a >> LB) < AW'(C_MEM_DEPTH);
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [AW-1:0] a);
        return IDX_W'(a >> LB);
    endfunction

    // Lanes covered by one beat: from the given byte offset up to the end of
    // the size-aligned container holding it.
    function automatic logic [NB-1:0] lane_mask(input logic [LB-1:0] offs, input logic [2:0] sz);
        int unsigned   lo;
        int unsigned   hi;
        int unsigned   step;
        logic [NB-1:0] m;
        lo   = 32'(offs);
        step = 32'd1 << sz;
        hi   = (lo & ~(step - 32'd1)) + step;
        m    = '0;
        for (int unsigned i = 0; i < NB; i++) begin
            m[i] = (i >= lo) && (i < hi);
        end
        return m;
    endfunction

    // ---------------------------------------------------------------- write
    w_state_t        w_state, w_state_nx;
    logic [IW-1:0]   w_id;
    logic [AW-1:0]   w_addr;
    logic [7:0]      w_len;
    logic [2:0]      w_size;
    logic [1:0]      w_burst;
    logic [7:0]      w_cnt;
    logic            w_err;
    logic [AW-1:0]   w_next_addr;
    logic            w_wrap_legal;
    logic            aw_ready, w_ready;
    logic            aw_hs, w_hs, w_at_len, w_done;
    logic            w_beat_err;
    logic [NB-1:0]   wr_strb;

    axi_burst_addr_gen #(.ADDR_WIDTH(AW)) u_waddr (
        .addr       (w_addr),
        .size       (w_size),
        .len        (w_len),
        .burst      (w_burst),
        .next_addr  (w_next_addr),
        .wrap_legal (w_wrap_legal)
    );

    assign aw_hs      = S_AXI_AWVALID && aw_ready;
    assign w_hs       = S_AXI_WVALID && w_ready;
    assign w_at_len   = (w_cnt == w_len);
    assign w_done     = w_hs && (S_AXI_WLAST || w_at_len);
    assign w_beat_err = (w_size > BUS_SIZE) || ((w_burst == BURST_WRAP) && !w_wrap_legal)
                        || !in_range(w_addr);
    assign wr_strb    = S_AXI_WSTRB & lane_mask(w_addr[LB-1:0], w_size);

    // Write FSM state register.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) w_state <= W_IDLE;
        else                w_state <= w_state_nx;
    end

    // Write FSM next state: a beat with WLAST or the final counted beat ends the burst.
    always_comb begin
        w_state_nx = w_state;
        case (w_state)
            W_IDLE:  if (aw_hs)        w_state_nx = W_DATA;
            W_DATA:  if (w_done)       w_state_nx = W_RESP;
            W_RESP:  if (S_AXI_BREADY) w_state_nx = W_IDLE;
            default:                   w_state_nx = W_IDLE;
        endcase
    end

    // Write FSM outputs; ready is gated by reset so it is low while reset is held.
    always_comb begin
        aw_ready     = S_AXI_ARESETN && (w_state == W_IDLE);
        w_ready      = (w_state == W_DATA);
        S_AXI_BVALID = (w_state == W_RESP);
        S_AXI_BRESP  = ((w_state == W_RESP) && w_err) ? RESP_SLVERR : RESP_OKAY;
        S_AXI_BID    = w_id;
    end

    assign S_AXI_AWREADY = aw_ready;
    assign S_AXI_WREADY  = w_ready;

    // Write burst context: latch on AW, then advance address and accumulate errors per beat.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            w_id    <= '0;
            w_addr  <= '0;
            w_len   <= '0;
            w_size  <= '0;
            w_burst <= '0;
            w_cnt   <= '0;
            w_err   <= 1'b0;
        end else if (aw_hs) begin
            w_id    <= S_AXI_AWID;
            w_addr  <= S_AXI_AWADDR;
            w_len   <= S_AXI_AWLEN;
            w_size  <= S_AXI_AWSIZE;
            w_burst <= S_AXI_AWBURST;
            w_cnt   <= '0;
            w_err   <= 1'b0;
        end else if (w_hs) begin
            w_addr  <= w_next_addr;
            w_cnt   <= w_cnt + 8'd1;
            w_err   <= w_err || w_beat_err || (S_AXI_WLAST != w_at_len);
        end
    end

    // Memory write port: byte-enabled, suppressed for errored beats.
    always_ff @(posedge S_AXI_ACLK) begin
        if (w_hs && !w_beat_err) begin
            for (int unsigned b = 0; b < NB; b++) begin
                if (wr_strb[b]) mem[word_idx(w_addr)][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
            end
        end
    end

    // ----------------------------------------------------------------- read
    r_state_t        r_state, r_state_nx;
    logic [IW-1:0]   r_id;
    logic [AW-1:0]   r_addr;
    logic [7:0]      r_len;
    logic [2:0]      r_size;
    logic [1:0]      r_burst;
    logic [7:0]      r_cnt;
    logic            r_err;
    logic            r_last_q;
    logic [DW-1:0]   r_data;
    logic [AW-1:0]   r_next_addr;
    logic            r_wrap_legal;
    logic            ar_ready, r_valid;
    logic            ar_hs, r_hs;
    logic            ar_burst_err, r_burst_err;
    logic [AW-1:0]   fetch_addr;
    logic            fetch_err, fetch_en;

    axi_burst_addr_gen #(.ADDR_WIDTH(AW)) u_raddr (
        .addr       (r_addr),
        .size       (r_size),
        .len        (r_len),
        .burst      (r_burst),
        .next_addr  (r_next_addr),
        .wrap_legal (r_wrap_legal)
    );

    assign ar_hs        = S_AXI_ARVALID && ar_ready;
    assign r_hs         = r_valid && S_AXI_RREADY;
    assign ar_burst_err = (S_AXI_ARSIZE > BUS_SIZE)
                          || ((S_AXI_ARBURST == BURST_WRAP) && !wrap_len_ok(S_AXI_ARLEN));
    assign r_burst_err  = (r_size > BUS_SIZE) || ((r_burst == BURST_WRAP) && !r_wrap_legal);

    // The beat being presented is always prefetched: the first from the AR
    // address, each following one from the generator on the R handshake.
    assign fetch_addr = ar_hs ? S_AXI_ARADDR : r_next_addr;
    assign fetch_err  = ar_hs ? (ar_burst_err || !in_range(S_AXI_ARADDR))
                              : (r_burst_err || !in_range(r_next_addr));
    assign fetch_en   = ar_hs || (r_hs && !r_last_q);

    // Read FSM state register.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) r_state <= R_IDLE;
        else                r_state <= r_state_nx;
    end

    // Read FSM next state: the handshake of the last beat returns to idle.
    always_comb begin
        r_state_nx = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs)             r_state_nx = R_DATA;
            R_DATA:  if (r_hs && r_last_q)  r_state_nx = R_IDLE;
            default:                        r_state_nx = R_IDLE;
        endcase
    end

    // Read FSM outputs; LAST and RESP are qualified by VALID so they reset to 0.
    always_comb begin
        ar_ready     = S_AXI_ARESETN && (r_state == R_IDLE);
        r_valid      = (r_state == R_DATA);
        S_AXI_RLAST  = r_valid && r_last_q;
        S_AXI_RRESP  = (r_valid && r_err) ? RESP_SLVERR : RESP_OKAY;
        S_AXI_RID    = r_id;
        S_AXI_RDATA  = r_data;
    end

    assign S_AXI_ARREADY = ar_ready;
    assign S_AXI_RVALID  = r_valid;

    // Read burst context: latch on AR, advance on each non-final R handshake.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_id     <= '0;
            r_addr   <= '0;
            r_len    <= '0;
            r_size   <= '0;
            r_burst  <= '0;
            r_cnt    <= '0;
            r_err    <= 1'b0;
            r_last_q <= 1'b0;
        end else if (ar_hs) begin
            r_id     <= S_AXI_ARID;
            r_addr   <= S_AXI_ARADDR;
            r_len    <= S_AXI_ARLEN;
            r_size   <= S_AXI_ARSIZE;
            r_burst  <= S_AXI_ARBURST;
            r_cnt    <= '0;
            r_err    <= fetch_err;
            r_last_q <= (S_AXI_ARLEN == 8'd0);
        end else if (r_hs && !r_last_q) begin
            r_addr   <= r_next_addr;
            r_cnt    <= r_cnt + 8'd1;
            r_err    <= fetch_err;
            r_last_q <= ((r_cnt + 8'd1) == r_len);
        end
    end

    // Memory read port: registered, zero for errored beats; holds while stalled.
    always_ff @(posedge S_AXI_ACLK) begin
        if (fetch_en) r_data <= fetch_err ? '0 : mem[word_idx(fetch_addr)];
    end

endmodule

// File: tb/tb_axi4_burst_mem.sv
// Scoreboard bench for axi4_burst_mem (32-bit bus, 1024-word memory).
module tb_axi4_burst_mem;

    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int IW    = 4;
    localparam int DEPTH = 1024;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [IW-1:0] awid, arid, bid, rid;
    logic [AW-1:0] awaddr, araddr;
    logic [7:0]    awlen, arlen;
    logic [2:0]    awsize, arsize;
    logic [1:0]    awburst, arburst, bresp, rresp;
    logic          awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic          arvalid, arready, rlast, rvalid, rready;
    logic [DW-1:0] wdata, rdata;
    logic [3:0]    wstrb;

    always #5 clk = ~clk;

    axi4_burst_mem #(
        .C_S_AXI_DATA_WIDTH (DW),
        .C_S_AXI_ADDR_WIDTH (AW),
        .C_S_AXI_ID_WIDTH   (IW),
        .C_MEM_DEPTH        (DEPTH)
    ) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .S_AXI_AWID    (awid),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWLEN   (awlen),
        .S_AXI_AWSIZE  (awsize),
        .S_AXI_AWBURST (awburst),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WLAST   (wlast),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BID     (bid),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARID    (arid),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARLEN   (arlen),
        .S_AXI_ARSIZE  (arsize),
        .S_AXI_ARBURST (arburst),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RID     (rid),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RLAST   (rlast),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready)
    );

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [3:0]  id;
    } rbeat_t;

    typedef struct {
        logic [3:0] id;
        logic [1:0] resp;
    } bexp_t;

    rbeat_t      r_q[$];
    bexp_t       b_q[$];
    logic [7:0]  ref_mem [0:DEPTH*4-1];
    logic [31:0] wdat [0:15];
    logic [3:0]  wstb [0:15];
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic wrap_ok(input logic [7:0] len);
        return (len == 1) || (len == 3) || (len == 7) || (len == 15);
    endfunction

    function automatic logic [31:0] beat_addr(input logic [31:0] start, input int i,
                                              input logic [2:0] size, input logic [7:0] len,
                                              input logic [1:0] burst);
        logic [31:0] step, blk, base;
        step = 32'd1 << size;
        if (burst == 2'b00) return start;
        if (burst == 2'b10 && wrap_ok(len)) begin
            blk  = (32'(len) + 32'd1) * step;
            base = start - (start % blk);
            return base + (((start - base) + 32'(i) * step) % blk);
        end
        if (i == 0) return start;
        return (start & ~(step - 32'd1)) + 32'(i) * step;
    endfunction

    function automatic logic beat_err(input logic [31:0] a, input logic [2:0] size,
                                      input logic [7:0] len, input logic [1:0] burst);
        return (size > 3'd2) || (burst == 2'b10 && !wrap_ok(len)) || ((a >> 2) >= DEPTH);
    endfunction

    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input int wlast_at);
        int          nb, guard;
        logic        err;
        logic [31:0] a, ba, step;
        bexp_t       e;
        nb   = (wlast_at >= 0 && wlast_at < int'(len)) ? wlast_at + 1 : int'(len) + 1;
        err  = (wlast_at != int'(len));
        step = 32'd1 << size;
        for (int i = 0; i < nb; i++) begin
            a = beat_addr(addr, i, size, len, burst);
            if (beat_err(a, size, len, burst)) err = 1'b1;
            else begin
                for (int b = 0; b < 4; b++) begin
                    ba = (a & ~32'd3) + 32'(b);
                    if (wstb[i][b] && ba >= a && ba < ((a & ~(step - 32'd1)) + step))
                        ref_mem[ba] = wdat[i][8*b +: 8];
                end
            end
        end
        e.id = id;
        e.resp = err ? 2'b10 : 2'b00;
        b_q.push_back(e);

        @(negedge clk);
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        guard = 0;
        while (!awready && guard < 50) begin @(negedge clk); guard++; end
        check("awready", awready, 1);
        @(negedge clk);
        awvalid = 1'b0;
        for (int i = 0; i < nb; i++) begin
            wdata = wdat[i]; wstrb = wstb[i]; wlast = (i == wlast_at); wvalid = 1'b1;
            guard = 0;
            while (!wready && guard < 50) begin @(negedge clk); guard++; end
            check("wready", wready, 1);
            @(negedge clk);
        end
        wvalid = 1'b0; wlast = 1'b0;
        check("wready_after_burst", wready, 0);
        bready = 1'b1;
        guard = 0;
        while (!bvalid && guard < 50) begin @(negedge clk); guard++; end
        e = b_q.pop_front();
        check("bvalid", bvalid, 1);
        check("bid", bid, e.id);
        check("bresp", bresp, e.resp);
        @(negedge clk);
        bready = 1'b0;
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input logic [3:0] pat);
        int          guard, cyc, got;
        logic [31:0] a, w;
        rbeat_t      x;
        for (int i = 0; i <= int'(len); i++) begin
            a = beat_addr(addr, i, size, len, burst);
            x.id   = id;
            x.last = (i == int'(len));
            if (beat_err(a, size, len, burst)) begin
                x.data = '0; x.resp = 2'b10;
            end else begin
                w = a & ~32'd3;
                x.data = {ref_mem[w+3], ref_mem[w+2], ref_mem[w+1], ref_mem[w]};
                x.resp = 2'b00;
            end
            r_q.push_back(x);
        end

        @(negedge clk);
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        guard = 0;
        while (!arready && guard < 50) begin @(negedge clk); guard++; end
        check("arready", arready, 1);
        @(negedge clk);
        arvalid = 1'b0;
        cyc = 0; got = 0;
        while (r_q.size() > 0 && cyc < 400) begin
            rready = pat[cyc % 4];
            if (rvalid) begin
                x = r_q[0];
                check("rdata", rdata, x.data);
                check("rresp", rresp, x.resp);
                check("rlast", rlast, x.last);
                check("rid", rid, x.id);
                if (rready) begin
                    x = r_q.pop_front();
                    got++;
                end
            end
            @(negedge clk);
            cyc++;
        end
        rready = 1'b0;
        r_q.delete();
        check("r_beats", got, int'(len) + 1);
        check("arready_after_read", arready, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
        rready = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_outputs", {awready, wready, bvalid, arready, rvalid, rlast, bresp, rresp}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_awready", awready, 1);
        check("idle_arready", arready, 1);

        // 16-beat INCR write and read-back
        for (int i = 0; i < 16; i++) begin
            wdat[i] = 32'(64'h11111111 * (i + 1));
            wstb[i] = 4'hF;
        end
        do_write(4'd1, 32'h0, 8'd15, 3'd2, 2'b01, 15);
        do_read(4'd2, 32'h0, 8'd15, 3'd2, 2'b01, 4'b1111);

        // WRAP read order
        for (int i = 0; i < 4; i++) wdat[i] = 32'hA0 + 32'(i);
        do_write(4'd3, 32'h10, 8'd3, 3'd2, 2'b01, 3);
        do_read(4'd4, 32'h18, 8'd3, 3'd2, 2'b10, 4'b1111);

        // Narrow unaligned INCR byte write
        wdat[0] = 32'hDEADBEEF; wdat[1] = 32'hCAFEF00D;
        do_write(4'd5, 32'h40, 8'd1, 3'd2, 2'b01, 1);
        wdat[0] = 32'hEEEE55EE; wstb[0] = 4'b0010;
        wdat[1] = 32'hEE66EEEE; wstb[1] = 4'b0100;
        wdat[2] = 32'h77EEEEEE; wstb[2] = 4'b1000;
        wdat[3] = 32'hEEEEEE88; wstb[3] = 4'b0001;
        do_write(4'd5, 32'h41, 8'd3, 3'd0, 2'b01, 3);
        do_read(4'd6, 32'h40, 8'd1, 3'd2, 2'b01, 4'b1111);
        for (int i = 0; i < 16; i++) wstb[i] = 4'hF;

        // Burst running off the end of memory
        for (int i = 0; i < 4; i++) wdat[i] = 32'h5A5A0000 + 32'(i);
        do_write(4'd7, 32'(DEPTH * 4 - 8), 8'd3, 3'd2, 2'b01, 3);
        do_read(4'd8, 32'(DEPTH * 4 - 8), 8'd3, 3'd2, 2'b01, 4'b1111);

        // RREADY back-pressure
        for (int i = 0; i < 8; i++) wdat[i] = 32'h0BAD0000 + 32'(i * 3);
        do_write(4'd9, 32'h100, 8'd7, 3'd2, 2'b01, 7);
        do_read(4'd9, 32'h100, 8'd7, 3'd2, 2'b01, 4'b1001);

        // Early and missing WLAST
        for (int i = 0; i < 8; i++) wdat[i] = 32'h20000000 + 32'(i);
        do_write(4'd1, 32'h200, 8'd7, 3'd2, 2'b01, 7);
        for (int i = 0; i < 4; i++) wdat[i] = 32'h3000_0000 + 32'(i);
        do_write(4'd2, 32'h200, 8'd3, 3'd2, 2'b01, 1);
        for (int i = 0; i < 4; i++) wdat[i] = 32'h4000_0000 + 32'(i);
        do_write(4'd3, 32'h210, 8'd3, 3'd2, 2'b01, -1);
        do_read(4'd4, 32'h200, 8'd7, 3'd2, 2'b01, 4'b1111);

        // Illegal WRAP length and oversize transfers
        do_write(4'd2, 32'h300, 8'd2, 3'd2, 2'b10, 2);
        do_read(4'd3, 32'h300, 8'd2, 3'd2, 2'b10, 4'b1111);
        do_write(4'd4, 32'h0, 8'd1, 3'd3, 2'b01, 1);
        do_read(4'd4, 32'h0, 8'd1, 3'd3, 2'b01, 4'b1111);

        // FIXED burst with varying strobes
        wdat[0] = 32'h11223344; wstb[0] = 4'b1111;
        wdat[1] = 32'hAABBCCDD; wstb[1] = 4'b0101;
        wdat[2] = 32'h99999999; wstb[2] = 4'b1000;
        do_write(4'd5, 32'h400, 8'd2, 3'd2, 2'b00, 2);
        do_read(4'd6, 32'h400, 8'd1, 3'd2, 2'b00, 4'b1111);
        for (int i = 0; i < 16; i++) wstb[i] = 4'hF;

        // Asynchronous reset in the middle of a write burst
        @(negedge clk);
        awid = 4'd7; awaddr = 32'h600; awlen = 8'd15; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
        guard = 0;
        while (!awready && guard < 50) begin @(negedge clk); guard++; end
        @(negedge clk);
        awvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wdata = 32'hF00D0000 + 32'(i); wstrb = 4'hF; wvalid = 1'b1;
            @(negedge clk);
        end
        check("wready_mid_burst", wready, 1);
        #2 rst_n = 1'b0;
        #1 check("async_reset_outputs", {awready, wready, bvalid, arready, rvalid}, 0);
        wvalid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) wdat[i] = 32'h600D0000 + 32'(i);
        do_write(4'd8, 32'h600, 8'd3, 3'd2, 2'b01, 3);
        do_read(4'd9, 32'h600, 8'd3, 3'd2, 2'b01, 4'b1111);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
